fwd_hazard_unit: RTL and testbench

- Parametrised successor to the single-issue EX-stage forwarding unit.
- Tracks in-flight producers over NSTG post-issue stages, each tagged with a result latency.
- Produces a per-operand forward-stage select for NSRC decode-stage source operands; NSRC=3 covers FP rs3 for fused ops.
- Raises `stall` on load-use or latency hazards, and optionally on long-latency (div/FP) busy-register hazards.

---
 rtl/fhu_pkg.sv | 26 ++
 rtl/fhu_checker.sv | 17 +
 rtl/fhu_src_match.sv | 42 ++++
 rtl/fwd_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fhu_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Optional busy-register scoreboard is enabled with the FHU_SCOREBOARD_EN macro.
package fhu_pkg;

    localparam int DEF_REGW = 5;
    localparam int DEF_LATW = 2;
    localparam int DEF_NSTG = 3;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    localparam logic [1:0] FWD_WB1   = 2'd3;

    typedef struct packed {
        logic                v;
        logic                we;
        logic [DEF_REGW-1:0] rd;
        logic [DEF_LATW-1:0] lat;
    } fhu_entry_t;

    // A producer k stages past issue is forwardable once k has reached its latency.
    function automatic logic lat_ready(input int k, input int lat);
        return (k >= lat);
    endfunction

endpackage

// File: rtl/fhu_checker.sv
// Simulation checks on the issue port of the forwarding / hazard unit.
module fhu_checker #(
    parameter int NSTG = 3,
    parameter int LATW = 2
) (
    input logic            clk,
    input logic            rst,
    input logic            hold,
    input logic            iss_valid,
    input logic            iss_we,
    input logic [LATW-1:0] iss_lat
);

    a_lat_in_range: assert property (@(posedge clk) disable iff (rst)
        (!hold && iss_valid && iss_we && (iss_lat != {LATW{1'b0}})) |-> (int'(iss_lat) <= NSTG));

endmodule

// File: rtl/fhu_src_match.sv
// Youngest-match priority search of the tracker for one decode source operand.
module fhu_src_match
    import fhu_pkg::*;
#(
    parameter int NSTG = 3,
    parameter int REGW = 5,
    parameter int LATW = 2,
    parameter int SELW = $clog2(NSTG + 1)
) (
    input  logic [REGW-1:0]      rs,
    input  logic                 rs_use,
    input  logic [NSTG-1:0]      trk_v,
    input  logic [NSTG-1:0]      trk_we,
    input  logic [NSTG*REGW-1:0] trk_rd,
    input  logic [NSTG*LATW-1:0] trk_lat,
    output logic [SELW-1:0]      sel,
    output logic                 not_ready
);

    logic found_s;

    // Walk from stage 1 outward so the first hit is the youngest producer.
    always_comb begin
        sel       = SELW'(FWD_RF);
        not_ready = 1'b0;
        found_s   = 1'b0;
        for (int k = 1; k <= NSTG; k++) begin
            if (!found_s && rs_use && (rs != {REGW{1'b0}}) && trk_v[k-1] && trk_we[k-1]
                && (trk_rd[(k-1)*REGW +: REGW] == rs)) begin
                found_s = 1'b1;
                if (lat_ready(k, int'(trk_lat[(k-1)*LATW +: LATW]))) begin
                    sel = SELW'(k);
                end else begin
                    not_ready = 1'b1;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Multi-operand forwarding select and load-use / latency stall generation.
// Define FHU_SCOREBOARD_EN to add busy-register tracking for long-latency (lat=0) producers.
module fwd_hazard_unit
    import fhu_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int NSTG = 3,
    parameter int REGW = DEF_REGW,
    parameter int LATW = DEF_LATW,
    parameter int SELW = $clog2(NSTG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 iss_valid,
    input  logic                 iss_we,
    input  logic [REGW-1:0]      iss_rd,
    input  logic [LATW-1:0]      iss_lat,
    input  logic [NSRC*REGW-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_use,
    input  logic                 id_we,
    input  logic [REGW-1:0]      id_rd,
    input  logic                 lc_done,
    input  logic [REGW-1:0]      lc_rd,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall
);

    logic [NSTG-1:0]      v_q, v_d;
    logic [NSTG-1:0]      we_q, we_d;
    logic [NSTG*REGW-1:0] rd_q, rd_d;
    logic [NSTG*LATW-1:0] lat_q, lat_d;
    logic                 iss_wr_s;
    logic [NSRC-1:0]      not_ready_s;
    logic                 sb_stall_s;

    // Long-latency issues never enter the shift tracker; they are handled by the scoreboard.
    assign iss_wr_s = iss_valid & iss_we & (iss_lat != {LATW{1'b0}});

    // Tracker ages one stage per unfrozen cycle; the oldest entry falls off.
    always_comb begin
        v_d   = v_q;
        we_d  = we_q;
        rd_d  = rd_q;
        lat_d = lat_q;
        if (!hold) begin
            for (int k = NSTG - 1; k >= 1; k--) begin
                v_d[k]               = v_q[k-1];
                we_d[k]              = we_q[k-1];
                rd_d[k*REGW +: REGW] = rd_q[(k-1)*REGW +: REGW];
                lat_d[k*LATW +: LATW] = lat_q[(k-1)*LATW +: LATW];
            end
            v_d[0]          = iss_valid;
            we_d[0]         = iss_wr_s;
            rd_d[0 +: REGW] = iss_rd;
            lat_d[0 +: LATW] = iss_lat;
        end else begin
            v_d = v_q;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= {NSTG{1'b0}};
            we_q  <= {NSTG{1'b0}};
            rd_q  <= {(NSTG*REGW){1'b0}};
            lat_q <= {(NSTG*LATW){1'b0}};
        end else begin
            v_q   <= v_d;
            we_q  <= we_d;
            rd_q  <= rd_d;
            lat_q <= lat_d;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fhu_src_match #(
            .NSTG(NSTG),
            .REGW(REGW),
            .LATW(LATW),
            .SELW(SELW)
        ) u_match (
            .rs       (id_rs[i*REGW +: REGW]),
            .rs_use   (id_rs_use[i]),
            .trk_v    (v_q),
            .trk_we   (we_q),
            .trk_rd   (rd_q),
            .trk_lat  (lat_q),
            .sel      (fwd_sel[i*SELW +: SELW]),
            .not_ready(not_ready_s[i])
        );
    end

`ifdef FHU_SCOREBOARD_EN
    logic [(2**REGW)-1:0] busy_q, busy_d;

    // Clear is applied first so that a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (lc_done) begin
            busy_d[lc_rd] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (!hold && iss_valid && iss_we && (iss_lat == {LATW{1'b0}})
            && (iss_rd != {REGW{1'b0}})) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d[0] = busy_d[0];
        end
    end

    // Busy-register scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= {(2**REGW){1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // RAW on any used operand or WAW on the decode destination while busy.
    always_comb begin
        sb_stall_s = id_we & busy_q[id_rd];
        for (int i = 0; i < NSRC; i++) begin
            if (id_rs_use[i] && busy_q[id_rs[i*REGW +: REGW]]) begin
                sb_stall_s = 1'b1;
            end else begin
                sb_stall_s = sb_stall_s;
            end
        end
    end
`else
    logic unused_lc_s;
    assign unused_lc_s = ^{lc_done, lc_rd};
    assign sb_stall_s  = 1'b0;
`endif

    assign stall = (|not_ready_s) | sb_stall_s;

    fhu_checker #(
        .NSTG(NSTG),
        .LATW(LATW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .iss_valid(iss_valid),
        .iss_we   (iss_we),
        .iss_lat  (iss_lat)
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized self-checking bench for fwd_hazard_unit against an issue-history model.
module tb_fwd_hazard_unit;

    localparam int NSRC = 3;
    localparam int NSTG = 3;
    localparam int REGW = 5;
    localparam int LATW = 2;
    localparam int SELW = 2;

    logic                 clk;
    logic                 rst;
    logic                 hold;
    logic                 iss_valid;
    logic                 iss_we;
    logic [REGW-1:0]      iss_rd;
    logic [LATW-1:0]      iss_lat;
    logic [NSRC*REGW-1:0] id_rs;
    logic [NSRC-1:0]      id_rs_use;
    logic                 id_we;
    logic [REGW-1:0]      id_rd;
    logic                 lc_done;
    logic [REGW-1:0]      lc_rd;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(
        .NSRC(NSRC), .NSTG(NSTG), .REGW(REGW), .LATW(LATW), .SELW(SELW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd), .iss_lat(iss_lat),
        .id_rs(id_rs), .id_rs_use(id_rs_use), .id_we(id_we), .id_rd(id_rd),
        .lc_done(lc_done), .lc_rd(lc_rd),
        .fwd_sel(fwd_sel), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of issues, newest first; index 0 is one cycle past issue.
    typedef struct {
        bit w;
        int rd;
        int lat;
    } rec_t;
    rec_t hq[$];
    bit   busy_m[32];
    int   exp_sel[NSRC];
    bit   exp_stall;

    function automatic void calc();
        int  rs;
        bit  found;
        exp_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            exp_sel[i] = 0;
            rs = int'(id_rs[i*REGW +: REGW]);
            found = 1'b0;
            if (id_rs_use[i] && rs != 0) begin
                for (int k = 1; k <= hq.size(); k++) begin
                    if (!found && hq[k-1].w && hq[k-1].rd == rs) begin
                        found = 1'b1;
                        if (k >= hq[k-1].lat) exp_sel[i] = k;
                        else exp_stall = 1'b1;
                    end
                end
`ifdef FHU_SCOREBOARD_EN
                if (busy_m[rs]) exp_stall = 1'b1;
`endif
            end
        end
`ifdef FHU_SCOREBOARD_EN
        if (id_we && busy_m[int'(id_rd)]) exp_stall = 1'b1;
`endif
    endfunction

    function automatic void update();
        rec_t r;
        if (rst) begin
            hq.delete();
            for (int j = 0; j < 32; j++) busy_m[j] = 1'b0;
        end else begin
`ifdef FHU_SCOREBOARD_EN
            if (lc_done) busy_m[int'(lc_rd)] = 1'b0;
`endif
            if (!hold) begin
                r.w   = iss_valid && iss_we && (iss_lat != 2'd0);
                r.rd  = int'(iss_rd);
                r.lat = int'(iss_lat);
                hq.push_front(r);
                if (hq.size() > NSTG) void'(hq.pop_back());
`ifdef FHU_SCOREBOARD_EN
                if (iss_valid && iss_we && iss_lat == 2'd0 && iss_rd != 5'd0)
                    busy_m[int'(iss_rd)] = 1'b1;
`endif
            end
        end
    endfunction

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel(input int i);
        return 32'(fwd_sel[i*SELW +: SELW]);
    endfunction

    // Check all outputs against the model, then clock once and age the model.
    task automatic step();
        #1;
        calc();
        for (int i = 0; i < NSRC; i++) ck("model_sel", sel(i), 32'(exp_sel[i]));
        ck("model_stall", 32'(stall), 32'(exp_stall));
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic clr();
        hold = 1'b0; iss_valid = 1'b0; iss_we = 1'b0; iss_rd = 5'd0; iss_lat = 2'd0;
        id_rs = 15'd0; id_rs_use = 3'd0; id_we = 1'b0; id_rd = 5'd0;
        lc_done = 1'b0; lc_rd = 5'd0;
    endtask

    task automatic issue(input int rd, input int lat);
        iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'(rd); iss_lat = 2'(lat);
    endtask

    task automatic use_rs(input int i, input int rs);
        id_rs[i*REGW +: REGW] = 5'(rs);
        id_rs_use[i] = 1'b1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        update();
        #1;
        step();
        rst = 1'b0;
        #1;
        ck("reset_stall", 32'(stall), 32'd0);
        ck("reset_sel", 32'(fwd_sel), 32'd0);

        // ALU back-to-back
        issue(5, 1); step(); clr(); use_rs(0, 5);
        #1; ck("alu_sel_k1", sel(0), 32'd1); ck("alu_stall", 32'(stall), 32'd0);
        step(); #1; ck("alu_sel_k2", sel(0), 32'd2);
        step(); clr();

        // Load-use
        issue(7, 2); step(); clr(); use_rs(1, 7);
        #1; ck("lu_stall", 32'(stall), 32'd1); ck("lu_sel", sel(1), 32'd0);
        step(); #1; ck("lu_stall_clear", 32'(stall), 32'd0); ck("lu_sel_k2", sel(1), 32'd2);
        step(); clr();

        // Priority and x0
        issue(3, 1); step(); issue(3, 1); step(); clr(); use_rs(0, 3);
        #1; ck("prio_sel", sel(0), 32'd1);
        step(); clr(); issue(0, 1); step(); clr(); use_rs(0, 0);
        #1; ck("x0_sel", sel(0), 32'd0); ck("x0_stall", 32'(stall), 32'd0);
        step(); clr(); step();

        // Hold freezes a not-ready load
        issue(7, 2); step(); clr(); use_rs(1, 7); hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; ck("hold_stall", 32'(stall), 32'd1);
            step();
        end
        hold = 1'b0;
        #1; ck("hold_release_stall", 32'(stall), 32'd1);
        step(); #1; ck("hold_after_stall", 32'(stall), 32'd0); ck("hold_after_sel", sel(1), 32'd2);
        step(); clr();

`ifdef FHU_SCOREBOARD_EN
        // Scoreboard RAW, same-cycle set/clear, WAW
        issue(9, 0); step(); clr(); use_rs(2, 9);
        #1; ck("sb_stall", 32'(stall), 32'd1);
        step(); #1; ck("sb_stall_held", 32'(stall), 32'd1);
        lc_done = 1'b1; lc_rd = 5'd9;
        #1; ck("sb_stall_lc_cycle", 32'(stall), 32'd1);
        step(); lc_done = 1'b0;
        #1; ck("sb_stall_drop", 32'(stall), 32'd0); ck("sb_sel_rf", sel(2), 32'd0);
        step(); clr();
        issue(9, 0); step(); clr();
        issue(9, 0); lc_done = 1'b1; lc_rd = 5'd9; step(); clr(); use_rs(2, 9);
        #1; ck("sb_set_wins", 32'(stall), 32'd1);
        step(); clr(); id_we = 1'b1; id_rd = 5'd9;
        #1; ck("sb_waw", 32'(stall), 32'd1);
        step(); clr(); lc_done = 1'b1; lc_rd = 5'd9; step(); clr();
`endif

        // Reset mid-flight
        issue(4, 0); step(); issue(6, 2); step(); clr();
        rst = 1'b1; step(); rst = 1'b0;
        use_rs(0, 6); use_rs(1, 4); id_we = 1'b1; id_rd = 5'd4;
        #1; ck("rst_mid_stall", 32'(stall), 32'd0); ck("rst_mid_sel", 32'(fwd_sel), 32'd0);
        step(); clr();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(99) == 0);
            hold      = ($urandom_range(7) == 0);
            iss_valid = $urandom_range(1);
            iss_we    = ($urandom_range(3) != 0);
            iss_rd    = 5'($urandom_range(7));
            iss_lat   = 2'($urandom_range(3));
            for (int i = 0; i < NSRC; i++) id_rs[i*REGW +: REGW] = 5'($urandom_range(7));
            id_rs_use = 3'($urandom_range(7));
            id_we     = $urandom_range(1);
            id_rd     = 5'($urandom_range(7));
            lc_done   = ($urandom_range(3) == 0);
            lc_rd     = 5'($urandom_range(7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
